// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle MIPS-subset control sequencer. It decodes the opcode
// and funct fields, steps through fetch/decode/execute/memory/writeback and drives
// every datapath control.
// Latency: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles. Each memory state
// (FETCH, MEM_READ, MEM_WRITE) adds MEM_WAIT cycles.
// Backpressure: run=0 holds the FSM in FETCH. HALT is left only through reset.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   run                 permits a new instruction to start from FETCH
//   opcode, funct, zero instruction fields and the ALU zero flag
//   PCWr .. PCSource    datapath controls, all forced to 0 while reset=1
//   state               current state encoding
//   retire              one-cycle pulse on the final cycle of each instruction
//   instr_count         retired-instruction counter, wraps modulo 2**CNT_W
//   illegal             sticky flag for an unsupported opcode or funct
//
// Optional feature macro: MC_BNE_EN adds bne (opcode 0x05) through the BRANCH state.
// When the macro is undefined, opcode 0x05 is treated as illegal.

module mc_control_fsm #(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             PCWr,
  output logic             Iord,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRwrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       Operation_ALU,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    I_EXEC    = 4'd10,
    I_WB      = 4'd11,
    HALT      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
`ifdef MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'h05;
`endif

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_CMP = 3'b111;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT);

  // State registers.
  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               illegal_q, illegal_d;

  // Ungated control values. They are forced to zero below while reset is high.
  logic       pcwr_c, iord_c, memrd_c, memwr_c, irw_c;
  logic       m2r_c, rw_c, rdst_c, asa_c, ret_c;
  logic [1:0] asb_c, pcs_c;
  logic [2:0] op_c;

  // R-type funct decode. R_EXEC and R_WB both use it, so the ALU operation stays
  // stable through writeback without needing a register.
  logic [2:0] r_op;
  logic       r_ok;
  logic       last_wait;
  logic       br_take;

  always_comb begin
    r_op = ALU_ADD;
    r_ok = 1'b1;
    case (funct)
      6'h20:   r_op = ALU_ADD;
      6'h22:   r_op = ALU_SUB;
      6'h24:   r_op = ALU_AND;
      6'h25:   r_op = ALU_OR;
      6'h26:   r_op = ALU_XOR;
      default: r_ok = 1'b0;
    endcase
  end

  assign last_wait = (wait_q == WAIT_LAST);

`ifdef MC_BNE_EN
  assign br_take = (opcode == OP_BNE) ? ~zero : zero;
`else
  assign br_take = zero;
`endif

  // Next-state and control decode.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    pcwr_c    = 1'b0;
    iord_c    = 1'b0;
    memrd_c   = 1'b0;
    memwr_c   = 1'b0;
    irw_c     = 1'b0;
    m2r_c     = 1'b0;
    rw_c      = 1'b0;
    rdst_c    = 1'b0;
    asa_c     = 1'b0;
    asb_c     = 2'b00;
    op_c      = ALU_ADD;
    pcs_c     = 2'b00;
    ret_c     = 1'b0;

    case (state_q)
      FETCH: begin
        // While run is low the FSM idles here. All controls are off and the
        // wait counter is frozen.
        if (run) begin
          memrd_c = 1'b1;
          asb_c   = 2'b01;
          if (last_wait) begin
            irw_c   = 1'b1;
            pcwr_c  = 1'b1;
            wait_d  = '0;
            state_d = DECODE;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end

      DECODE: begin
        // Precompute the branch target (PC + imm<<2) into ALU_out_hold.
        asb_c = 2'b11;
        case (opcode)
          OP_RTYPE:      state_d = R_EXEC;
          OP_LW, OP_SW:  state_d = MEM_ADDR;
          OP_BEQ:        state_d = BRANCH;
`ifdef MC_BNE_EN
          OP_BNE:        state_d = BRANCH;
`endif
          OP_J:          state_d = JUMP;
          OP_ADDI:       state_d = I_EXEC;
          default: begin
            state_d   = HALT;
            illegal_d = 1'b1;
          end
        endcase
      end

      MEM_ADDR: begin
        asa_c   = 1'b1;
        asb_c   = 2'b10;
        state_d = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      end

      MEM_READ: begin
        memrd_c = 1'b1;
        iord_c  = 1'b1;
        if (last_wait) begin
          wait_d  = '0;
          state_d = MEM_WB;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      MEM_WB: begin
        rw_c    = 1'b1;
        ret_c   = 1'b1;
        state_d = FETCH;
      end

      MEM_WRITE: begin
        // The address is held for every wait cycle. The write strobe fires only
        // on the last cycle, so memory sees exactly one write.
        iord_c = 1'b1;
        if (last_wait) begin
          memwr_c = 1'b1;
          ret_c   = 1'b1;
          wait_d  = '0;
          state_d = FETCH;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      R_EXEC: begin
        asa_c = 1'b1;
        op_c  = r_op;
        if (r_ok) begin
          state_d = R_WB;
        end else begin
          state_d   = HALT;
          illegal_d = 1'b1;
        end
      end

      R_WB: begin
        rw_c    = 1'b1;
        rdst_c  = 1'b1;
        m2r_c   = 1'b1;
        op_c    = r_op;
        ret_c   = 1'b1;
        state_d = FETCH;
      end

      BRANCH: begin
        asa_c   = 1'b1;
        op_c    = ALU_CMP;
        pcs_c   = 2'b01;
        pcwr_c  = br_take;
        ret_c   = 1'b1;
        state_d = FETCH;
      end

      JUMP: begin
        pcs_c   = 2'b10;
        pcwr_c  = 1'b1;
        ret_c   = 1'b1;
        state_d = FETCH;
      end

      I_EXEC: begin
        asa_c   = 1'b1;
        asb_c   = 2'b10;
        state_d = I_WB;
      end

      I_WB: begin
        rw_c    = 1'b1;
        m2r_c   = 1'b1;
        ret_c   = 1'b1;
        state_d = FETCH;
      end

      HALT: begin
        state_d = HALT;
      end

      default: begin
        // Unused encodings recover to FETCH.
        state_d = FETCH;
        wait_d  = '0;
      end
    endcase
  end

  // While reset is high every control output and retire is held at zero, so an
  // abandoned instruction cannot write memory, the register file or the PC.
  assign PCWr          = pcwr_c  & ~reset;
  assign Iord          = iord_c  & ~reset;
  assign MemRead       = memrd_c & ~reset;
  assign MemWrite      = memwr_c & ~reset;
  assign IRwrite       = irw_c   & ~reset;
  assign MemtoReg      = m2r_c   & ~reset;
  assign RegWrite      = rw_c    & ~reset;
  assign RegDst        = rdst_c  & ~reset;
  assign ALUSrcA       = asa_c   & ~reset;
  assign ALUSrcB       = reset ? 2'b00 : asb_c;
  assign Operation_ALU = reset ? 3'b000 : op_c;
  assign PCSource      = reset ? 2'b00 : pcs_c;
  assign retire        = ret_c   & ~reset;

  assign cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      wait_q    <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  assign state       = state_q;
  assign instr_count = cnt_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, run, zero;
  logic [5:0] opcode, funct;

  // Instance with single-cycle memory.
  logic        PCWr0, Iord0, MemRead0, MemWrite0, IRwrite0, MemtoReg0, RegWrite0, RegDst0, ALUSrcA0, retire0, illegal0;
  logic [1:0]  ALUSrcB0, PCSource0;
  logic [2:0]  Op0;
  logic [3:0]  state0;
  logic [31:0] cnt0;

  // Instance with two memory wait states.
  logic        PCWr2, Iord2, MemRead2, MemWrite2, IRwrite2, MemtoReg2, RegWrite2, RegDst2, ALUSrcA2, retire2, illegal2;
  logic [1:0]  ALUSrcB2, PCSource2;
  logic [2:0]  Op2;
  logic [3:0]  state2;
  logic [31:0] cnt2;

  mc_control_fsm #(.MEM_WAIT(0), .CNT_W(32), .WAIT_W(4)) dut0 (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct(funct), .zero(zero),
    .PCWr(PCWr0), .Iord(Iord0), .MemRead(MemRead0), .MemWrite(MemWrite0), .IRwrite(IRwrite0),
    .MemtoReg(MemtoReg0), .RegWrite(RegWrite0), .RegDst(RegDst0), .ALUSrcA(ALUSrcA0),
    .ALUSrcB(ALUSrcB0), .Operation_ALU(Op0), .PCSource(PCSource0), .state(state0),
    .retire(retire0), .instr_count(cnt0), .illegal(illegal0)
  );

  mc_control_fsm #(.MEM_WAIT(2), .CNT_W(32), .WAIT_W(4)) dut2 (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct(funct), .zero(zero),
    .PCWr(PCWr2), .Iord(Iord2), .MemRead(MemRead2), .MemWrite(MemWrite2), .IRwrite(IRwrite2),
    .MemtoReg(MemtoReg2), .RegWrite(RegWrite2), .RegDst(RegDst2), .ALUSrcA(ALUSrcA2),
    .ALUSrcB(ALUSrcB2), .Operation_ALU(Op2), .PCSource(PCSource2), .state(state2),
    .retire(retire2), .instr_count(cnt2), .illegal(illegal2)
  );

  // Control bus packing:
  // {PCWr,Iord,MemRead,MemWrite,IRwrite,MemtoReg,RegWrite,RegDst,ALUSrcA,ALUSrcB,Op,PCSource,retire}
  logic [16:0] c0, c2;
  assign c0 = {PCWr0, Iord0, MemRead0, MemWrite0, IRwrite0, MemtoReg0, RegWrite0, RegDst0,
               ALUSrcA0, ALUSrcB0, Op0, PCSource0, retire0};
  assign c2 = {PCWr2, Iord2, MemRead2, MemWrite2, IRwrite2, MemtoReg2, RegWrite2, RegDst2,
               ALUSrcA2, ALUSrcB2, Op2, PCSource2, retire2};

  function automatic logic [16:0] mk(input logic pcwr, input logic iord, input logic mr,
                                     input logic mw, input logic irw, input logic m2r,
                                     input logic rw, input logic rd, input logic asa,
                                     input logic [1:0] asb, input logic [2:0] op,
                                     input logic [1:0] pcs, input logic ret);
    return {pcwr, iord, mr, mw, irw, m2r, rw, rd, asa, asb, op, pcs, ret};
  endfunction

  logic [16:0] E_IDLE, E_FETCH, E_FWAIT, E_DEC, E_MADDR, E_MRD, E_MWB, E_MWR_W, E_MWR;
  logic [16:0] E_REX_ADD, E_REX_SUB, E_RWB_ADD, E_RWB_SUB, E_BR_T, E_BR_N, E_J, E_IEX, E_IWB;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk0(input string tag, input logic [3:0] st, input logic [16:0] ctl);
    chk({tag, "_state"}, {28'd0, state0}, {28'd0, st});
    chk({tag, "_ctl"}, {15'd0, c0}, {15'd0, ctl});
  endtask

  task automatic chk2(input string tag, input logic [3:0] st, input logic [16:0] ctl);
    chk({tag, "_state2"}, {28'd0, state2}, {28'd0, st});
    chk({tag, "_ctl2"}, {15'd0, c2}, {15'd0, ctl});
  endtask

  // Advance one clock edge. Sampling happens 2 time units after the edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    //                pcwr iord mr mw irw m2r rw rd asa asb    op      pcs    ret
    E_IDLE    = '0;
    E_FETCH   = mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 0);
    E_FWAIT   = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 0);
    E_DEC     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b000, 2'b00, 0);
    E_MADDR   = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 2'b00, 0);
    E_MRD     = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0);
    E_MWB     = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 3'b000, 2'b00, 1);
    E_MWR_W   = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0);
    E_MWR     = mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 1);
    E_REX_ADD = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b000, 2'b00, 0);
    E_REX_SUB = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 2'b00, 0);
    E_RWB_ADD = mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 2'b00, 3'b000, 2'b00, 1);
    E_RWB_SUB = mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 2'b00, 3'b001, 2'b00, 1);
    E_BR_T    = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b111, 2'b01, 1);
    E_BR_N    = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b111, 2'b01, 1);
    E_J       = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 1);
    E_IEX     = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 2'b00, 0);
    E_IWB     = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 3'b000, 2'b00, 1);

    // Reset is held for two cycles with run=1. All controls must be forced to zero.
    reset = 1'b1; run = 1'b1; opcode = 6'h00; funct = 6'h20; zero = 1'b0;
    cyc();
    chk0("rst", 4'd0, E_IDLE);
    chk("rst_cnt", cnt0, 32'd0);
    chk("rst_ill", {31'd0, illegal0}, 32'd0);
    chk2("rst", 4'd0, E_IDLE);
    cyc();
    reset = 1'b0; #1;

    // R-type add.
    chk0("add_f", 4'd0, E_FETCH);
    cyc(); chk0("add_d", 4'd1, E_DEC);
    cyc(); chk0("add_x", 4'd6, E_REX_ADD);
    cyc(); chk0("add_wb", 4'd7, E_RWB_ADD);
    chk("add_cnt_pre", cnt0, 32'd0);
    cyc(); chk0("add_end", 4'd0, E_FETCH);
    chk("add_cnt", cnt0, 32'd1);

    // R-type sub.
    funct = 6'h22;
    cyc(); chk0("sub_d", 4'd1, E_DEC);
    cyc(); chk0("sub_x", 4'd6, E_REX_SUB);
    cyc(); chk0("sub_wb", 4'd7, E_RWB_SUB);
    cyc(); chk("sub_cnt", cnt0, 32'd2);

    // lw: states 0,1,2,3,4.
    opcode = 6'h23;
    cyc(); chk0("lw_d", 4'd1, E_DEC);
    cyc(); chk0("lw_a", 4'd2, E_MADDR);
    cyc(); chk0("lw_r", 4'd3, E_MRD);
    cyc(); chk0("lw_wb", 4'd4, E_MWB);
    cyc(); chk0("lw_end", 4'd0, E_FETCH);
    chk("lw_cnt", cnt0, 32'd3);

    // sw. run drops mid-instruction, which has no effect until the next FETCH.
    opcode = 6'h2B;
    cyc(); chk0("sw_d", 4'd1, E_DEC);
    run = 1'b0;
    cyc(); chk0("sw_a", 4'd2, E_MADDR);
    cyc(); chk0("sw_w", 4'd5, E_MWR);
    cyc(); chk0("sw_idle", 4'd0, E_IDLE);
    chk("sw_cnt", cnt0, 32'd4);
    cyc(); chk0("sw_idle2", 4'd0, E_IDLE);
    run = 1'b1; #1;
    chk0("sw_resume", 4'd0, E_FETCH);

    // beq, first taken and then not taken.
    opcode = 6'h04; zero = 1'b1;
    cyc(); chk0("beqt_d", 4'd1, E_DEC);
    cyc(); chk0("beqt_b", 4'd8, E_BR_T);
    cyc(); chk("beqt_cnt", cnt0, 32'd5);
    zero = 1'b0;
    cyc(); chk0("beqn_d", 4'd1, E_DEC);
    cyc(); chk0("beqn_b", 4'd8, E_BR_N);
    cyc(); chk("beqn_cnt", cnt0, 32'd6);

    // j.
    opcode = 6'h02;
    cyc(); chk0("j_d", 4'd1, E_DEC);
    cyc(); chk0("j_j", 4'd9, E_J);
    cyc(); chk("j_cnt", cnt0, 32'd7);

    // addi.
    opcode = 6'h08;
    cyc(); chk0("addi_d", 4'd1, E_DEC);
    cyc(); chk0("addi_x", 4'd10, E_IEX);
    cyc(); chk0("addi_wb", 4'd11, E_IWB);
    cyc(); chk0("addi_end", 4'd0, E_FETCH);
    chk("addi_cnt", cnt0, 32'd8);

    // Hold run=0 for 10 cycles after reset.
    reset = 1'b1; run = 1'b0; opcode = 6'h00; funct = 6'h20;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk0("hold", 4'd0, E_IDLE);
      chk("hold_cnt", cnt0, 32'd0);
    end
    run = 1'b1; #1;
    chk0("hold_go", 4'd0, E_FETCH);
    cyc(); chk0("hold_go_d", 4'd1, E_DEC);

    // MEM_WAIT=2 sw: FETCH for 3 cycles and MEM_WRITE for 3 cycles, 8 cycles in total.
    reset = 1'b1; opcode = 6'h2B;
    cyc();
    reset = 1'b0; #1;
    chk2("sw2_f0", 4'd0, E_FWAIT);
    cyc(); chk2("sw2_f1", 4'd0, E_FWAIT);
    cyc(); chk2("sw2_f2", 4'd0, E_FETCH);
    cyc(); chk2("sw2_d", 4'd1, E_DEC);
    cyc(); chk2("sw2_a", 4'd2, E_MADDR);
    cyc(); chk2("sw2_w0", 4'd5, E_MWR_W);
    cyc(); chk2("sw2_w1", 4'd5, E_MWR_W);
    cyc(); chk2("sw2_w2", 4'd5, E_MWR);
    chk("sw2_cnt_pre", cnt2, 32'd0);
    cyc(); chk2("sw2_end", 4'd0, E_FWAIT);
    chk("sw2_cnt", cnt2, 32'd1);

    // Illegal opcode: HALT is sticky and ignores run.
    reset = 1'b1; opcode = 6'h3F;
    cyc();
    reset = 1'b0;
    cyc(); chk0("ill_d", 4'd1, E_DEC);
    cyc();
    for (int i = 0; i < 20; i++) begin
      chk0("ill_halt", 4'd12, E_IDLE);
      chk("ill_flag", {31'd0, illegal0}, 32'd1);
      chk("ill_cnt", cnt0, 32'd0);
      cyc();
    end
    reset = 1'b1;
    cyc();
    chk("ill_rst_state", {28'd0, state0}, 32'd0);
    chk("ill_rst_flag", {31'd0, illegal0}, 32'd0);
    reset = 1'b0;

    // Illegal R-type funct: HALT without a register write.
    opcode = 6'h00; funct = 6'h2A;
    cyc(); chk0("rill_d", 4'd1, E_DEC);
    cyc(); chk0("rill_x", 4'd6, E_REX_ADD);
    cyc(); chk0("rill_halt", 4'd12, E_IDLE);
    chk("rill_flag", {31'd0, illegal0}, 32'd1);
    cyc(); chk0("rill_halt2", 4'd12, E_IDLE);
    chk("rill_cnt", cnt0, 32'd0);

    // bne (opcode 0x05) with zero=0.
    reset = 1'b1; funct = 6'h20; opcode = 6'h05; zero = 1'b0;
    cyc();
    reset = 1'b0;
    cyc(); chk0("bne_d", 4'd1, E_DEC);
    cyc();
`ifdef MC_BNE_EN
    chk0("bne_b", 4'd8, E_BR_T);
    chk("bne_ill", {31'd0, illegal0}, 32'd0);
`else
    chk0("bne_halt", 4'd12, E_IDLE);
    chk("bne_ill", {31'd0, illegal0}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Parametrised control FSM for the multi-cycle MIPS-subset datapath, replacing the hand-driven switch control bus. It decodes the IR opcode and funct fields and sequences the classic fetch/decode/execute/memory/writeback steps, driving every datapath control. It adds features the switch-driven datapath lacks:
- configurable memory wait states
- run/hold gating
- illegal-instruction halt
- retired-instruction counter

Parameters:
MEM_WAIT, 0, extra cycles each memory-access state is held before advancing (0 = single-cycle memory)
CNT_W, 32, width of retired-instruction counter
WAIT_W, 4, width of wait-state counter; MEM_WAIT must be < 2**WAIT_W

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
run  in  1  1 = allowed to start a new instruction from FETCH
opcode  in  6  instruction[31:26]
funct  in  6  instruction[5:0]
zero  in  1  ALU zero flag
PCWr  out  1  PC write enable (already gated with zero for branches)
Iord  out  1  0 = PC addresses memory, 1 = ALU_out_hold
MemRead  out  1  memory read enable
MemWrite  out  1  memory write enable
IRwrite  out  1  instruction register load
MemtoReg  out  1  0 = MDR to register file, 1 = ALU_out_hold
RegWrite  out  1  register file write
RegDst  out  1  0 = rt, 1 = rd
ALUSrcA  out  1  0 = PC, 1 = A
ALUSrcB  out  2  00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
Operation_ALU  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 111 beq-compare
PCSource  out  2  00 = ALU_out, 01 = ALU_out_hold, 10 = jump address
state  out  4  current state encoding
retire  out  1  one-cycle pulse on final cycle of each instruction
instr_count  out  CNT_W  retired-instruction count
illegal  out  1  sticky, set on unsupported opcode/funct

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high, port `reset`.
- Reset values: state=FETCH(0), instr_count=0, illegal=0, wait counter=0. All control outputs and retire are forced to 0 during any cycle with reset=1. Reset mid-instruction abandons it; the first post-reset cycle is FETCH.
- Default control value is 0 in every state unless listed.
- State encodings and per-state outputs:
  - FETCH(0): if run=0, all controls 0 and stay in FETCH. If run=1, drive MemRead=1, Iord=0, ALUSrcA=0, ALUSrcB=01, op=000, PCSource=00. IRwrite=1 and PCWr=1 only on the last wait cycle, then go to DECODE.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, op=000, which precomputes the branch target into ALU_out_hold. Dispatch on opcode:
    - 0x00 -> R_EXEC
    - 0x23 or 0x2B -> MEM_ADDR
    - 0x04 -> BRANCH
    - 0x02 -> JUMP
    - 0x08 -> I_EXEC
    - other -> HALT, set illegal
  - MEM_ADDR(2): ALUSrcA=1, ALUSrcB=10, op=000. Go to MEM_READ if opcode=0x23, else MEM_WRITE.
  - MEM_READ(3): MemRead=1, Iord=1 for all wait cycles, then MEM_WB.
  - MEM_WB(4): RegWrite=1, RegDst=0, MemtoReg=0; retire. Next FETCH.
  - MEM_WRITE(5): Iord=1. MemWrite=1 only on last wait cycle; retire on that cycle. Next FETCH.
  - R_EXEC(6): ALUSrcA=1, ALUSrcB=00. op from funct: 0x20->000, 0x22->001, 0x24->010, 0x25->011, 0x26->100. Any other funct -> HALT, set illegal, no register write. Otherwise next R_WB.
  - R_WB(7): RegWrite=1, RegDst=1, MemtoReg=1, and op held from funct; retire. Next FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, op=111, PCSource=01, PCWr=zero; retire. Next FETCH.
  - JUMP(9): PCSource=10, PCWr=1; retire. Next FETCH.
  - I_EXEC(10): ALUSrcA=1, ALUSrcB=10, op=000. Next I_WB.
  - I_WB(11): RegWrite=1, RegDst=0, MemtoReg=1; retire. Next FETCH.
  - HALT(12): all controls 0, run ignored, remain until reset.
- Wait counter: FETCH, MEM_READ and MEM_WRITE each occupy MEM_WAIT+1 cycles. The counter clears on state exit and does not advance in FETCH while run=0.
- Cycles per instruction with MEM_WAIT=0: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each memory state adds MEM_WAIT cycles.
- instr_count increments on every retire cycle and wraps modulo 2**CNT_W.
- run is sampled only in FETCH; deasserting it mid-instruction has no effect until the next FETCH.

Optional Feature:
MC_BNE_EN.
- Defined: opcode 0x05 (bne) dispatches from DECODE to BRANCH. In BRANCH, PCWr = ~zero when opcode=0x05, zero otherwise.
- Undefined: opcode 0x05 is illegal (HALT, illegal=1).

Test Plan:
- reset=1 for 2 cycles, then run=1, opcode=0x00, funct=0x20 -> states 0,1,6,7,0; RegWrite=1, RegDst=1, MemtoReg=1 only in state 7; retire pulse once; instr_count=1.
- opcode=0x23 (lw), MEM_WAIT=0 -> states 0,1,2,3,4; Iord=1, MemRead=1 in state 3; RegWrite=1, MemtoReg=0 in state 4; 5 cycles total.
- opcode=0x04 with zero=1, then with zero=0 -> BRANCH reached in 3rd cycle, PCSource=01 both times; PCWr=1 then PCWr=0; instr_count advances by 2.
- MEM_WAIT=2, opcode=0x2B -> FETCH lasts 3 cycles with IRwrite only on 3rd; MEM_WRITE lasts 3 cycles with MemWrite only on 3rd; 8 cycles total.
- run=0 held 10 cycles after reset -> state=0, PCWr=IRwrite=MemRead=0 throughout, instr_count=0. Then run=1 -> fetch proceeds on the next cycle.
- opcode=0x3F, or R-type funct=0x2A -> HALT(12), illegal=1, no RegWrite, held for 20 cycles. reset -> state=0, illegal=0. With MC_BNE_EN, opcode=0x05 and zero=0 -> PCWr=1 in BRANCH.
